// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory pipeline stage.
// Services one word read or write at a time with a fixed access latency,
// stalls the requester meanwhile, and rejects illegal or out-of-range requests.
//
// Handshake: a request (req_rd or req_wr) is accepted in IDLE on the rising
// edge where it is seen; stall=1 tells the requester to hold req_* stable.
// When stall drops, the access has completed this cycle: rd_valid (reads)
// or err (rejections) pulses for that one cycle, and the requester may present
// its next request in the cycle that follows.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic out_of_range;
  logic any_req;
  logic accept;
  logic finish;

  // Any address bit above the index range makes the request illegal
  generate
    if (ADDR_W > IDX_W) begin : g_range
      assign out_of_range = |req_addr[ADDR_W-1:IDX_W];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign any_req = req_rd | req_wr;
  assign finish  = (state == BUSY) && (cnt == 4'd0);

  // Next-state, accept decision and stall
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        // gated by rst so a held request cannot stall the pipeline during reset
        stall = rst & any_req;
        if ((req_rd & req_wr) || (any_req && out_of_range)) begin
          state_nx = ERR;
        end else if (any_req) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latched request, latency counter and registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
      if (accept) begin
        op_wr <= req_wr;
        idx   <= req_addr[IDX_W-1:0];
        wdata <= req_wdata;
        cnt   <= CNT_INIT;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (finish && !op_wr) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[idx];
      end
      if ((state == IDLE) && (state_nx == ERR)) err <= 1'b1;
    end
  end

  // Array write at the end of the BUSY window; contents survive reset
  always_ff @(posedge clk) begin
    if (finish && op_wr) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 2, 1, 15)
// with independent request buses sharing one clock and reset.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd    [3];
  logic        req_wr    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        stall     [3];
  logic        rd_valid  [3];
  logic        err       [3];
  logic [31:0] rd_data   [3];

  int          lat_of [3];
  logic [31:0] model  [3][256];
  logic [31:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  // clock
  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req_rd(req_rd[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .stall(stall[0]),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .err(err[0]));

  data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_rd(req_rd[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .stall(stall[1]),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .err(err[1]));

  data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(15)) u2 (
    .clk(clk), .rst(rst), .req_rd(req_rd[2]), .req_wr(req_wr[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .stall(stall[2]),
    .rd_valid(rd_valid[2]), .rd_data(rd_data[2]), .err(err[2]));

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    req_rd[u]    = rd;
    req_wr[u]    = wr;
    req_addr[u]  = addr;
    req_wdata[u] = data;
  endtask

  // One legal access; leaves the request asserted through DONE so the next
  // access can follow with minimum spacing
  task automatic access(input int u, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
    int n;
    logic [7:0] a;
    a = addr[7:0];
    if (!wr) exp_q.push_back(model[u][a]);
    @(posedge clk); #1;
    drive(u, !wr, wr, addr, data);
    @(negedge clk);
    check1("accept_rd_valid", rd_valid[u], 1'b0);
    check32("accept_rd_data", rd_data[u], 32'h0);
    check1("accept_err", err[u], 1'b0);
    n = 0;
    while (stall[u] && n < 40) begin
      n++;
      @(negedge clk);
    end
    check32("stall_cycles", 32'(n), 32'(lat_of[u] + 1));
    check1("done_rd_valid", rd_valid[u], !wr);
    if (!wr) check32("done_rd_data", rd_data[u], exp_q.pop_front());
    else     check32("done_rd_data_wr", rd_data[u], 32'h0);
    check1("done_err", err[u], 1'b0);
    if (wr) model[u][a] = data;
  endtask

  // Drop the request and confirm the response pulse has ended
  task automatic idle(input int u);
    @(posedge clk); #1;
    drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check1("idle_stall", stall[u], 1'b0);
    check1("idle_rd_valid", rd_valid[u], 1'b0);
    check32("idle_rd_data", rd_data[u], 32'h0);
    check1("idle_err", err[u], 1'b0);
  endtask

  // Rejected request: one stall cycle, one err pulse, no rd_valid
  task automatic bad(input int u, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    drive(u, rd, wr, addr, data);
    @(negedge clk);
    check1("bad_stall_first", stall[u], 1'b1);
    check1("bad_err_first", err[u], 1'b0);
    @(posedge clk); #1;
    drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check1("bad_err_pulse", err[u], 1'b1);
    check1("bad_stall_err", stall[u], 1'b0);
    check1("bad_rd_valid_err", rd_valid[u], 1'b0);
    @(negedge clk);
    check1("bad_err_after", err[u], 1'b0);
    check1("bad_rd_valid_after", rd_valid[u], 1'b0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    lat_of[0] = 2;
    lat_of[1] = 1;
    lat_of[2] = 15;
    rst = 1'b0;
    for (int u = 0; u < 3; u++) drive(u, 1'b1, 1'b0, 32'h0, 32'h0);

    // Reset held with a read request pending
    repeat (3) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        check1("rst_stall", stall[u], 1'b0);
        check1("rst_rd_valid", rd_valid[u], 1'b0);
        check32("rst_rd_data", rd_data[u], 32'h0);
        check1("rst_err", err[u], 1'b0);
      end
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    // Write then read back, LATENCY=2
    access(0, 1'b1, 32'd5, 32'hDEADBEEF);
    access(0, 1'b0, 32'd5, 32'h0);
    idle(0);

    // Seed values that the rejected requests must not disturb
    access(0, 1'b1, 32'd0, 32'hCAFEF00D);
    access(0, 1'b1, 32'd3, 32'h12345678);
    idle(0);

    // Out-of-range write must not alias onto index 0
    bad(0, 1'b0, 1'b1, 32'h100, 32'h0BADBAD0);
    access(0, 1'b0, 32'd0, 32'h0);
    idle(0);

    // Simultaneous read and write is illegal
    bad(0, 1'b1, 1'b1, 32'd3, 32'hFFFFFFFF);
    access(0, 1'b0, 32'd3, 32'h0);
    idle(0);

    // Reset during BUSY drops the pending write
    access(0, 1'b1, 32'd7, 32'h11111111);
    idle(0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd7, 32'hAAAA5555);
    @(negedge clk);
    check1("midrst_stall_idle", stall[0], 1'b1);
    @(negedge clk);
    check1("midrst_stall_busy", stall[0], 1'b1);
    #1 rst = 1'b0;
    #1;
    check1("midrst_async_stall", stall[0], 1'b0);
    check1("midrst_async_rd_valid", rd_valid[0], 1'b0);
    check32("midrst_async_rd_data", rd_data[0], 32'h0);
    check1("midrst_async_err", err[0], 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    access(0, 1'b0, 32'd7, 32'h0);
    idle(0);

    // Latency sweep with back-to-back accesses
    for (int u = 1; u < 3; u++) begin
      for (int i = 0; i < 4; i++)
        access(u, 1'b1, 32'(i), 32'h5A000000 | 32'(u << 8) | 32'(i));
      for (int i = 0; i < 4; i++)
        access(u, 1'b0, 32'(i), 32'h0);
      idle(u);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the processor's memory stage. It is the target side of the wmem/rmem request interface that the memory pipeline stage drives.
- Accepts one word read or write at a time. Models a fixed multi-cycle access latency and holds the pipeline with a stall signal until the access completes.
- Returns read data with a one-cycle valid pulse and flags illegal or out-of-range requests.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, request address width
DEPTH, 256, number of words in the array; power of two
LATENCY, 2, BUSY cycles per access; legal range 1..15

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_rd  input  1  read request from the memory stage
req_wr  input  1  write request from the memory stage
req_addr  input  ADDR_W  word address (one word per address)
req_wdata  input  DATA_W  write data
stall  output  1  holds the pipeline while a request is being serviced
rd_valid  output  1  one-cycle pulse: rd_data holds the read result
rd_data  output  DATA_W  read result; 0 when not valid
err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0; stall=0, rd_valid=0, rd_data=0, err=0.
  - Latched request registers are cleared.
  - The memory array is not cleared; its contents persist across reset and are undefined after power-up.
- Index and range: index = req_addr[log2(DEPTH)-1:0]. The request is out of range if any of req_addr[ADDR_W-1:log2(DEPTH)] is nonzero.
- Initiator contract: the requester keeps req_* stable while stall=1. Changes during stall are ignored because the request is latched on acceptance.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - stall = req_rd | req_wr (combinational, same cycle).
  - If req_rd & req_wr, or the address is out of range, go to ERR. Nothing is latched and nothing is written.
  - Otherwise, if one request is high: latch op, index and wdata, set cnt=LATENCY-1, go to BUSY.
  - If no request: stay in IDLE.
- BUSY:
  - stall=1.
  - If cnt!=0: cnt decrements.
  - If cnt==0 at the edge:
    - Write: mem[index] <= wdata.
    - Read: rd_data register <= mem[index].
    - Go to DONE.
- DONE:
  - stall=0. rd_valid=1 for reads, 0 for writes.
  - rd_data holds the read word for this cycle only, then returns to 0.
  - Always go to IDLE. Any request visible in DONE is ignored; the requester advances on this edge and presents its next request in the following IDLE cycle.
- ERR: stall=0, err=1 for one cycle, then IDLE. A rejected request never produces rd_valid.
- Timing:
  - Stall spans LATENCY+1 cycles per valid access (IDLE cycle plus LATENCY BUSY cycles).
  - Response appears LATENCY+1 cycles after the request is first seen.
  - An error request stalls for exactly one cycle.
- Read-after-write: a read issued after a write completes returns the new data. Only one access is in flight, so no hazard exists.
- Reset asserted mid-access:
  - The transaction is aborted immediately and any pending write is dropped (the array is unchanged).
  - Outputs go to their reset values asynchronously.
- Back-to-back requests: minimum spacing is one idle cycle between DONE and the next acceptance. Two-access throughput is 2*(LATENCY+2) cycles.
- rd_data, rd_valid and err are registered outputs. stall is combinational in IDLE and registered-state-derived elsewhere.

Test Plan:
- Reset state: hold rst=0 for 3 cycles with req_rd=1 -> stall=0, rd_valid=0, rd_data=0, err=0 throughout.
- Write then read, LATENCY=2:
  - Write req_addr=5, wdata=0xDEADBEEF -> stall high for 3 cycles, then DONE with rd_valid=0.
  - Then read addr 5 -> stall for 3 cycles, then rd_valid=1 with rd_data=0xDEADBEEF for exactly 1 cycle, followed by rd_data=0.
- Out-of-range address:
  - Write to addr 0x100 with DEPTH=256 -> err=1 for 1 cycle, stall for 1 cycle, no rd_valid.
  - A later read of addr 0 returns its prior value; the error request must not alias onto index 0.
- Illegal op: req_rd=1 and req_wr=1 at addr 3 -> err pulse; a later read of addr 3 returns its previous contents (0x12345678 written earlier).
- Reset mid-write:
  - Start a write of 0xAAAA5555 to addr 7, holding old value 0x11111111; drop rst during BUSY -> outputs reset at once.
  - After release, a read of addr 7 returns 0x11111111.
- Latency sweep and back-to-back: with LATENCY=1 and LATENCY=15, issue reads to addrs 0..3 back-to-back -> each stall lasts LATENCY+1 cycles, results come out in order, and each rd_valid is a single cycle.
